// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode types: opcodes, formats, ALU/compare ops, control bundle
// and the per-opcode legal-funct3 masks.
package decode_stage_pkg;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'h03,
        OP_IMM    = 7'h13,
        OP_AUIPC  = 7'h17,
        OP_STORE  = 7'h23,
        OP_OP     = 7'h33,
        OP_LUI    = 7'h37,
        OP_BRANCH = 7'h63,
        OP_JALR   = 7'h67,
        OP_JAL    = 7'h6F,
        OP_SYSTEM = 7'h73
    } opcode_t;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } inst_format_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SLL  = 4'h1,
        ALU_SLT  = 4'h2,
        ALU_SLTU = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SRL  = 4'h5,
        ALU_OR   = 4'h6,
        ALU_AND  = 4'h7,
        ALU_SUB  = 4'h8,
        ALU_SRA  = 4'hD
    } alu_op_t;

    typedef enum logic [2:0] {
        CMP_EQ   = 3'd0,
        CMP_NE   = 3'd1,
        CMP_SLT  = 3'd2,
        CMP_SLTU = 3'd3,
        CMP_LT   = 3'd4,
        CMP_GE   = 3'd5,
        CMP_LTU  = 3'd6,
        CMP_GEU  = 3'd7
    } cmp_op_t;

    typedef struct packed {
        logic       branch;
        logic       jump;
        logic       compare;
        logic       cmp_imm;
        cmp_op_t    cmp_op;
        logic       alu_imm;
        logic       alu_pc;
        alu_op_t    alu_op;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_size;
        logic       mem_unsigned;
    } decode_ctrl_t;

    // Bit n set means funct3 == n is a legal encoding for that opcode.
    localparam logic [7:0] LOAD_F3_OK   = 8'b0011_0111;
    localparam logic [7:0] STORE_F3_OK  = 8'b0000_0111;
    localparam logic [7:0] BRANCH_F3_OK = 8'b1111_0011;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage;
// master = fetch/execute environment, slave = decode_stage.
interface decode_stage_if #(
    parameter int PC_WIDTH    = 32,
    parameter int QUEUE_DEPTH = 4
);
    import decode_stage_pkg::*;

    logic                               flush;
    logic                               in_valid;
    logic                               in_ready;
    logic [31:0]                        in_instr;
    logic [PC_WIDTH-1:0]                in_pc;
    logic                               out_valid;
    logic                               out_ready;
    logic [PC_WIDTH-1:0]                out_pc;
    logic [31:0]                        out_instr;
    inst_format_t                       out_format;
    logic [4:0]                         out_rs1;
    logic [4:0]                         out_rs2;
    logic [4:0]                         out_rd;
    decode_ctrl_t                       out_ctrl;
    logic                               out_illegal;
    logic [$clog2(QUEUE_DEPTH+1)-1:0]   count;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_format,
               out_rs1, out_rs2, out_rd, out_ctrl, out_illegal, count
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_format,
               out_rs1, out_rs2, out_rd, out_ctrl, out_illegal, count
    );

endinterface

// File: rtl/decode_stage_queue.sv
// Generic FIFO with flush; push-to-head visibility 1 cycle, occupancy via count.
// No internal backpressure: caller must not push when full or pop when empty.
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_dat,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);

endmodule

// File: rtl/decode_stage.sv
// RV32I(E) decode stage: queue -> combinational decode -> output register; push-to-valid 2 edges.
// in_ready = !full && !flush, independent of out_ready; bundle held while out_valid && !out_ready.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4,
    parameter bit RV32E       = 1'b0,
    parameter int PC_WIDTH    = 32
) (
    input  logic           clk,
    input  logic           rst,
    decode_stage_if.slave  io
);
    localparam int QW = 32 + PC_WIDTH;

    logic                                q_full, q_empty, q_push, q_pop, in_ready;
    logic [QW-1:0]                       q_head;
    logic [$clog2(QUEUE_DEPTH+1)-1:0]    q_count;
    logic [31:0]                         instr;
    logic [PC_WIDTH-1:0]                 pc;

    logic                out_valid_q, out_illegal_q;
    logic [PC_WIDTH-1:0] out_pc_q;
    logic [31:0]         out_instr_q;
    inst_format_t        out_format_q;
    logic [4:0]          out_rs1_q, out_rs2_q, out_rd_q;
    decode_ctrl_t        out_ctrl_q;

    assign in_ready = !q_full && !io.flush;
    assign q_push   = io.in_valid && in_ready;
    assign q_pop    = !io.flush && !q_empty && (!out_valid_q || io.out_ready);

    decode_queue #(.DEPTH(QUEUE_DEPTH), .WIDTH(QW)) u_queue (
        .clk      (clk),
        .rst      (rst),
        .flush    (io.flush),
        .push     (q_push),
        .push_dat ({io.in_instr, io.in_pc}),
        .pop      (q_pop),
        .head_dat (q_head),
        .count    (q_count),
        .full     (q_full),
        .empty    (q_empty)
    );

    assign instr = q_head[QW-1 -: 32];
    assign pc    = q_head[PC_WIDTH-1:0];

    logic [6:0]   opc, f7;
    logic [2:0]   f3;
    inst_format_t d_fmt;
    logic [4:0]   d_rs1, d_rs2, d_rd;
    decode_ctrl_t d_ctrl;
    logic         d_ill, use_rs1, use_rs2, use_rd;

    always_comb begin
        opc    = instr[6:0];
        f3     = instr[14:12];
        f7     = instr[31:25];
        d_fmt  = FMT_R;
        d_rs1  = instr[19:15];
        d_rs2  = instr[24:20];
        d_rd   = instr[11:7];
        d_ill  = 1'b0;
        d_ctrl = '0;
        d_ctrl.cmp_op       = cmp_op_t'(f3);
        d_ctrl.alu_op       = ALU_ADD;
        d_ctrl.mem_size     = f3[1:0];
        d_ctrl.mem_unsigned = f3[2];
        case (opc)
            OP_OP: begin
                d_ctrl.alu_op  = alu_op_t'({f7[5], f3});
                d_ctrl.compare = (f3 == 3'd2) || (f3 == 3'd3);
                d_ill = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
            end
            OP_IMM: begin
                d_fmt          = FMT_I;
                d_ctrl.alu_op  = alu_op_t'({(f3 == 3'd5) && f7[5], f3});
                d_ctrl.compare = (f3 == 3'd2) || (f3 == 3'd3);
                d_ctrl.cmp_imm = 1'b1;
                d_ctrl.alu_imm = 1'b1;
                // Only the shift-immediates carry funct7 in the immediate field.
                if (f3 == 3'd1)      d_ill = (f7 != 7'h00);
                else if (f3 == 3'd5) d_ill = (f7 != 7'h00) && (f7 != 7'h20);
            end
            OP_LOAD: begin
                d_fmt           = FMT_I;
                d_ctrl.alu_imm  = 1'b1;
                d_ctrl.mem_read = 1'b1;
                d_ill = !LOAD_F3_OK[f3];
            end
            OP_STORE: begin
                d_fmt            = FMT_S;
                d_ctrl.alu_imm   = 1'b1;
                d_ctrl.mem_write = 1'b1;
                d_ill = !STORE_F3_OK[f3];
            end
            OP_BRANCH: begin
                d_fmt          = FMT_B;
                d_ctrl.branch  = 1'b1;
                d_ctrl.alu_imm = 1'b1;
                d_ctrl.alu_pc  = 1'b1;
                d_ill = !BRANCH_F3_OK[f3];
            end
            OP_JALR: begin
                d_fmt          = FMT_I;
                d_ctrl.jump    = 1'b1;
                d_ctrl.alu_imm = 1'b1;
                d_ill = (f3 != 3'd0);
            end
            OP_JAL: begin
                d_fmt          = FMT_J;
                d_ctrl.jump    = 1'b1;
                d_ctrl.alu_imm = 1'b1;
                d_ctrl.alu_pc  = 1'b1;
            end
            OP_LUI: begin
                d_fmt          = FMT_U;
                d_rs1          = 5'd0;
                d_ctrl.alu_imm = 1'b1;
            end
            OP_AUIPC: begin
                d_fmt          = FMT_U;
                d_ctrl.alu_imm = 1'b1;
                d_ctrl.alu_pc  = 1'b1;
            end
            OP_SYSTEM: d_fmt = FMT_I;
            default:   d_ill = 1'b1;
        endcase

        case (d_fmt)
            FMT_R:        {use_rs1, use_rs2, use_rd} = 3'b111;
            FMT_I:        {use_rs1, use_rs2, use_rd} = 3'b101;
            FMT_S, FMT_B: {use_rs1, use_rs2, use_rd} = 3'b110;
            default:      {use_rs1, use_rs2, use_rd} = 3'b001;
        endcase
        if (RV32E && ((use_rs1 && d_rs1[4]) || (use_rs2 && d_rs2[4]) || (use_rd && d_rd[4])))
            d_ill = 1'b1;

        // Illegal words still flow downstream but must never trigger side effects.
        if (d_ill) d_ctrl = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            out_pc_q      <= '0;
            out_instr_q   <= '0;
            out_format_q  <= FMT_R;
            out_rs1_q     <= '0;
            out_rs2_q     <= '0;
            out_rd_q      <= '0;
            out_ctrl_q    <= '0;
            out_illegal_q <= 1'b0;
        end else if (io.flush) begin
            out_valid_q <= 1'b0;
        end else if (q_pop) begin
            out_valid_q   <= 1'b1;
            out_pc_q      <= pc;
            out_instr_q   <= instr;
            out_format_q  <= d_fmt;
            out_rs1_q     <= d_rs1;
            out_rs2_q     <= d_rs2;
            out_rd_q      <= d_rd;
            out_ctrl_q    <= d_ctrl;
            out_illegal_q <= d_ill;
        end else if (out_valid_q && io.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign io.in_ready    = in_ready;
    assign io.count       = q_count;
    assign io.out_valid   = out_valid_q;
    assign io.out_pc      = out_pc_q;
    assign io.out_instr   = out_instr_q;
    assign io.out_format  = out_format_q;
    assign io.out_rs1     = out_rs1_q;
    assign io.out_rs2     = out_rs2_q;
    assign io.out_rd      = out_rd_q;
    assign io.out_ctrl    = out_ctrl_q;
    assign io.out_illegal = out_illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: RV32I and RV32E instances share one stimulus stream and
// are checked every cycle against a queue-level model plus directed literal checks.
module tb_decode_stage;
    import decode_stage_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;

    int n_pass  = 0;
    int n_total = 0;

    decode_stage_if #(.PC_WIDTH(32), .QUEUE_DEPTH(DEPTH)) if0 ();
    decode_stage_if #(.PC_WIDTH(32), .QUEUE_DEPTH(DEPTH)) if1 ();

    assign if0.flush = flush;     assign if1.flush = flush;
    assign if0.in_valid = in_valid; assign if1.in_valid = in_valid;
    assign if0.in_instr = in_instr; assign if1.in_instr = in_instr;
    assign if0.in_pc = in_pc;     assign if1.in_pc = in_pc;
    assign if0.out_ready = out_ready; assign if1.out_ready = out_ready;

    decode_stage #(.QUEUE_DEPTH(DEPTH), .RV32E(1'b0), .PC_WIDTH(32)) dut0 (.clk(clk), .rst(rst), .io(if0));
    decode_stage #(.QUEUE_DEPTH(DEPTH), .RV32E(1'b1), .PC_WIDTH(32)) dut1 (.clk(clk), .rst(rst), .io(if1));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    typedef struct packed {
        inst_format_t fmt;
        logic [4:0]   rs1, rs2, rd;
        decode_ctrl_t ctrl;
        logic         ill;
    } exp_t;

    // Expected decode written directly from the ISA rules, using raw opcode values.
    function automatic exp_t ref_decode(input logic [31:0] w, input bit e);
        exp_t x;
        logic [6:0] opc, f7;
        logic [2:0] f3;
        bit is_op, is_imm, is_ld, is_st, is_br, is_jalr, is_jal, is_lui, is_auipc, is_sys;
        bit shift, bad_reg;
        opc = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        is_op = (opc == 7'h33); is_imm = (opc == 7'h13); is_ld = (opc == 7'h03);
        is_st = (opc == 7'h23); is_br = (opc == 7'h63); is_jalr = (opc == 7'h67);
        is_jal = (opc == 7'h6F); is_lui = (opc == 7'h37); is_auipc = (opc == 7'h17);
        is_sys = (opc == 7'h73);
        shift = is_imm && (f3 == 3'd1 || f3 == 3'd5);
        x = '0;
        x.fmt = (is_imm || is_ld || is_jalr || is_sys) ? FMT_I :
                is_st ? FMT_S : is_br ? FMT_B : (is_lui || is_auipc) ? FMT_U :
                is_jal ? FMT_J : FMT_R;
        x.rs1 = is_lui ? 5'd0 : w[19:15];
        x.rs2 = w[24:20];
        x.rd  = w[11:7];
        x.ill = !(is_op || is_imm || is_ld || is_st || is_br || is_jalr || is_jal ||
                  is_lui || is_auipc || is_sys)
             || (is_op && !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))))
             || (shift && !(f7 == 7'h00 || (f3 == 3'd5 && f7 == 7'h20)))
             || (is_ld && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7))
             || (is_st && f3 > 3'd2)
             || (is_br && (f3 == 3'd2 || f3 == 3'd3))
             || (is_jalr && f3 != 3'd0);
        bad_reg = 1'b0;
        if (x.fmt != FMT_U && x.fmt != FMT_J && w[19]) bad_reg = 1'b1;
        if ((x.fmt == FMT_R || x.fmt == FMT_S || x.fmt == FMT_B) && w[24]) bad_reg = 1'b1;
        if (x.fmt != FMT_S && x.fmt != FMT_B && w[11]) bad_reg = 1'b1;
        if (e && bad_reg) x.ill = 1'b1;
        if (!x.ill) begin
            x.ctrl.branch       = is_br;
            x.ctrl.jump         = is_jal || is_jalr;
            x.ctrl.compare      = (is_op || is_imm) && (f3 == 3'd2 || f3 == 3'd3);
            x.ctrl.cmp_imm      = is_imm;
            x.ctrl.cmp_op       = cmp_op_t'(f3);
            x.ctrl.alu_imm      = is_imm || is_ld || is_st || is_br || is_lui || is_auipc || is_jal || is_jalr;
            x.ctrl.alu_pc       = is_br || is_auipc || is_jal;
            if (is_op)       x.ctrl.alu_op = alu_op_t'({f7[5], f3});
            else if (is_imm) x.ctrl.alu_op = alu_op_t'({(f3 == 3'd5) & f7[5], f3});
            else             x.ctrl.alu_op = ALU_ADD;
            x.ctrl.mem_read     = is_ld;
            x.ctrl.mem_write    = is_st;
            x.ctrl.mem_size     = f3[1:0];
            x.ctrl.mem_unsigned = f3[2];
        end
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference pipe: pending words in order plus the word held at the output.
    logic [63:0] mq[$];
    logic [63:0] m_item;
    bit          m_ov;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_ov = 1'b0;
        end else begin
            bit acc, pop;
            acc = in_valid && !flush && (mq.size() < DEPTH);
            pop = !flush && (mq.size() > 0) && (!m_ov || out_ready);
            if (flush) begin
                mq.delete();
                m_ov = 1'b0;
            end else begin
                if (pop) begin
                    m_item = mq.pop_front();
                    m_ov = 1'b1;
                end else if (m_ov && out_ready) begin
                    m_ov = 1'b0;
                end
                if (acc) mq.push_back({in_instr, in_pc});
            end
        end
    end

    task automatic cmp_bundle(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                              input inst_format_t fmt, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input decode_ctrl_t ctrl, input logic ill, input bit e);
        exp_t x;
        x = ref_decode(m_item[63:32], e);
        chk({tag, "_pc"},      64'(pc),   64'(m_item[31:0]));
        chk({tag, "_instr"},   64'(ins),  64'(m_item[63:32]));
        chk({tag, "_format"},  64'(fmt),  64'(x.fmt));
        chk({tag, "_rs1"},     64'(rs1),  64'(x.rs1));
        chk({tag, "_rs2"},     64'(rs2),  64'(x.rs2));
        chk({tag, "_rd"},      64'(rd),   64'(x.rd));
        chk({tag, "_ctrl"},    64'(ctrl), 64'(x.ctrl));
        chk({tag, "_illegal"}, 64'(ill),  64'(x.ill));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready",  64'(if0.in_ready),  64'(!flush && mq.size() < DEPTH));
            chk("in_ready_e", 64'(if1.in_ready), 64'(!flush && mq.size() < DEPTH));
            chk("count",     64'(if0.count),     64'(mq.size()));
            chk("count_e",   64'(if1.count),     64'(mq.size()));
            chk("out_valid", 64'(if0.out_valid), 64'(m_ov));
            chk("out_valid_e", 64'(if1.out_valid), 64'(m_ov));
            if (m_ov) begin
                cmp_bundle("i", if0.out_pc, if0.out_instr, if0.out_format, if0.out_rs1, if0.out_rs2,
                           if0.out_rd, if0.out_ctrl, if0.out_illegal, 1'b0);
                cmp_bundle("e", if1.out_pc, if1.out_instr, if1.out_format, if1.out_rs1, if1.out_rs2,
                           if1.out_rd, if1.out_ctrl, if1.out_illegal, 1'b1);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w, input logic [31:0] p);
        in_valid = 1'b1; in_instr = w; in_pc = p;
        step();
        in_valid = 1'b0;
        chk("lat_early", 64'(if0.out_valid), 64'd0);
        step();
        chk("lat_valid", 64'(if0.out_valid), 64'd1);
        chk("lat_pc",    64'(if0.out_pc),    64'(p));
    endtask

    function automatic logic [31:0] mkaddi(input int i);
        logic [11:0] imm;
        logic [4:0]  rd;
        imm = 12'(i);
        rd  = 5'(i + 1);
        return {imm, 5'd0, 3'b000, rd, 7'h13};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  opc;
        int k;
        r = $urandom();
        k = $urandom_range(0, 11);
        case (k)
            0: opc = 7'h33;  1: opc = 7'h13;  2: opc = 7'h03;  3: opc = 7'h23;
            4: opc = 7'h63;  5: opc = 7'h67;  6: opc = 7'h6F;  7: opc = 7'h37;
            8: opc = 7'h17;  9: opc = 7'h73;  10: opc = r[6:0];
            default: opc = 7'h13;
        endcase
        if (k <= 1) begin
            case ($urandom_range(0, 2))
                0: r[31:25] = 7'h00;
                1: r[31:25] = 7'h20;
                default: ;
            endcase
        end
        if ($urandom_range(0, 1) == 1) begin
            r[24] = 1'b0; r[19] = 1'b0; r[11] = 1'b0;
        end
        return {r[31:7], opc};
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
        repeat (3) step();
        chk("rst_valid",   64'(if0.out_valid),   64'd0);
        chk("rst_count",   64'(if0.count),       64'd0);
        chk("rst_pc",      64'(if0.out_pc),      64'd0);
        chk("rst_instr",   64'(if0.out_instr),   64'd0);
        chk("rst_format",  64'(if0.out_format),  64'd0);
        chk("rst_rs1",     64'(if0.out_rs1),     64'd0);
        chk("rst_rd",      64'(if0.out_rd),      64'd0);
        chk("rst_ctrl",    64'(if0.out_ctrl),    64'd0);
        chk("rst_illegal", 64'(if0.out_illegal), 64'd0);
        rst = 1'b0;
        step();

        // ADD x3,x1,x2
        send(32'h002081B3, 32'h100);
        chk("t1_rs1",    64'(if0.out_rs1),         64'd1);
        chk("t1_rs2",    64'(if0.out_rs2),         64'd2);
        chk("t1_rd",     64'(if0.out_rd),          64'd3);
        chk("t1_alu_op", 64'(if0.out_ctrl.alu_op), 64'(ALU_ADD));
        chk("t1_format", 64'(if0.out_format),      64'(FMT_R));
        chk("t1_illegal", 64'(if0.out_illegal),    64'd0);
        repeat (2) step();

        // Fill with execute stalled: 4 queued + 1 held, sixth word refused.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_instr = mkaddi(i); in_pc = 32'h200 + 32'(4 * i);
            step();
        end
        chk("t2_in_ready", 64'(if0.in_ready),  64'd0);
        chk("t2_count",    64'(if0.count),     64'd4);
        chk("t2_valid",    64'(if0.out_valid), 64'd1);
        chk("t2_head_pc",  64'(if0.out_pc),    64'h200);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            step();
            chk("t2_drain_valid", 64'(if0.out_valid), 64'd1);
            chk("t2_drain_pc",    64'(if0.out_pc),    64'(32'h200 + 32'(4 * i)));
            chk("t2_drain_count", 64'(if0.count),     64'(4 - i));
        end
        step();
        chk("t2_empty_valid", 64'(if0.out_valid), 64'd0);

        // Flush with a word presented while three are queued.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_instr = mkaddi(10 + i); in_pc = 32'h300 + 32'(4 * i);
            step();
        end
        in_valid = 1'b0;
        chk("t3_count_pre", 64'(if0.count), 64'd3);
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'h7FF00013; in_pc = 32'hBAD0;
        #1;
        chk("t3_in_ready_flush", 64'(if0.in_ready), 64'd0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("t3_count",  64'(if0.count),     64'd0);
        chk("t3_valid",  64'(if0.out_valid), 64'd0);
        out_ready = 1'b1;
        repeat (3) begin
            step();
            chk("t3_no_ghost", 64'(if0.out_valid), 64'd0);
        end

        send(32'hFFFFFFFF, 32'h400);
        chk("t4_illegal",   64'(if0.out_illegal),        64'd1);
        chk("t4_mem_write", 64'(if0.out_ctrl.mem_write), 64'd0);
        chk("t4_jump",      64'(if0.out_ctrl.jump),      64'd0);
        step();
        // ADDI x17,x0,1: fine on RV32I, illegal on RV32E.
        send(32'h00100893, 32'h404);
        chk("t4_e_illegal", 64'(if1.out_illegal), 64'd1);
        chk("t4_e_ctrl",    64'(if1.out_ctrl),    64'd0);
        chk("t4_i_illegal", 64'(if0.out_illegal), 64'd0);
        step();

        // LUI x1,0x12345
        send(32'h123450B7, 32'h500);
        chk("t5_format",  64'(if0.out_format),       64'(FMT_U));
        chk("t5_rs1",     64'(if0.out_rs1),          64'd0);
        chk("t5_rd",      64'(if0.out_rd),           64'd1);
        chk("t5_alu_imm", 64'(if0.out_ctrl.alu_imm), 64'd1);
        chk("t5_alu_pc",  64'(if0.out_ctrl.alu_pc),  64'd0);
        step();

        // Asynchronous reset in the middle of a drain.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_instr = mkaddi(20 + i); in_pc = 32'h600 + 32'(4 * i);
            step();
        end
        in_valid = 1'b0;
        chk("t6_count_pre", 64'(if0.count), 64'd2);
        out_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("t6_valid", 64'(if0.out_valid), 64'd0);
        chk("t6_count", 64'(if0.count),     64'd0);
        chk("t6_pc",    64'(if0.out_pc),    64'd0);
        step();
        rst = 1'b0;
        step();
        send(32'h002081B3, 32'h700);
        chk("t6_resume_rd", 64'(if0.out_rd), 64'd3);
        step();

        for (int n = 0; n < 2500; n++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_instr  = rand_instr();
            in_pc     = $urandom();
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 49) == 0);
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (8) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
